wallace_mac: RTL and testbench
==============================

// Module: wallace_mac
// PURPOSE
//  Multiply-accumulate stage downstream of the 4-bit wallace multiplier.
//  - Accepts a stream of 4-bit operand pairs over a valid/ready handshake.
//  - Registers each pair and multiplies it with one instance of wallace.
//  - Sums the 8-bit products over a frame that in_last terminates.
//  - Presents the frame sum, term count and overflow flag on a valid/ready output.
// PARAMETERS
//  ACC_W  16  accumulator and out_sum width (>= 8)
//  CNT_W   8  term counter width; the counter saturates at 2**CNT_W-1
// PORTS
//  clk        in   1      single clock; all state updates on the rising edge
//  rst        in   1      synchronous reset, active-high
//  in_valid   in   1      operand pair valid
//  in_ready   out  1      block can accept a pair this cycle
//  in_a       in   4      multiplicand
//  in_b       in   4      multiplier
//  in_last    in   1      pair is the final term of the frame
//  out_valid  out  1      frame result valid
//  out_ready  in   1      consumer accepts the result
//  out_sum    out  ACC_W  sum of products, modulo 2**ACC_W
//  out_count  out  CNT_W  number of terms in the frame (saturating)
//  out_ovf    out  1      sticky: the accumulator carried out during the frame
// BEHAVIOUR
//  Reset (rst=1 at a clk edge):
//   - state=S_ACC, in_ready=1, out_valid=0, out_sum=0, out_count=0, out_ovf=0.
//   - The operand register, accumulator and counter are cleared.
//   - A partial frame is discarded.
//  Accept: a pair is accepted when in_valid && in_ready at an edge.
//   - The pair is captured into p_a/p_b/p_last, and p_vld is set for one cycle.
//  Retire: in the cycle after acceptance (p_vld=1), prod=wallace(p_a,p_b).
//   - Non-last term: acc<=acc+zext(prod); cnt<=sat(cnt+1); ovf|=carry out of ACC_W.
//   - Last term: out_sum<=acc+prod, out_count<=sat(cnt+1), out_ovf<=ovf|carry, out_valid<=1.
//   - On the last term, acc, cnt and ovf clear in the same edge.
//  Latency: last pair accepted at edge k -> out_valid=1 after edge k+1 (2 cycles).
//  FSM (in_ready = state==S_ACC):
//   - S_ACC: accept pairs. Accepting with in_last=1 -> S_DRAIN.
//   - S_DRAIN: the last term retires this cycle -> S_HOLD.
//   - S_HOLD: out_valid=1 and outputs held stable. When out_valid && out_ready -> S_ACC, out_valid<=0.
//  Boundaries:
//   - Single-term frame is legal: out_sum=a*b, out_count=1.
//   - in_valid bubbles leave acc and cnt unchanged.
//   - in_valid while in_ready=0 is ignored; the pair is not lost and is taken once ready.
//   - out_ready during S_ACC/S_DRAIN has no effect.
//   - Accumulator overflow wraps; only out_ovf reports it.
//   - Count saturation does not set out_ovf.
//   - out_ready and in_valid both high in S_HOLD: the result is released; the input waits one cycle.
// STRUCTURE
//  Package wallace_pkg:
//   - OP_W=4, PROD_W=8.
//   - typedef enum {S_ACC,S_DRAIN,S_HOLD} mac_state_t.
//  Sub-module: the existing combinational wallace(a,b,prod), one instance fed from p_a/p_b.
//  Everything else is flat in wallace_mac: FSM, operand register, accumulator.
// TESTING
//  1. Frame (3,5),(7,9,last)
//     -> out_sum=78, out_count=2, out_ovf=0; out_valid rises 2 cycles after the last accept.
//  2. Single pair (15,15,last)
//     -> out_sum=225, out_count=1; in_ready=0 until out handshake.
//  3. ACC_W=10, five pairs (15,15), the last flagged
//     -> out_sum=101 (1125 mod 1024), out_count=5, out_ovf=1.
//  4. Backpressure: hold out_ready=0 for 5 cycles with in_valid=1
//     -> out_sum stable, in_ready=0, no pair accepted; in_ready=1 the cycle after handshake.
//  5. Reset mid-frame: (4,4),(5,5), rst one cycle, then (2,3,last)
//     -> out_sum=6, out_count=1, out_ovf=0.
//  6. Full sweep a,b in 1..15 (one-pair frames), in_valid gaps inserted
//     -> every out_sum==a*b; bubbles never change results.

Source files
------------

// File: rtl/wallace_pkg.sv
// Shared definitions for the wallace multiplier and the wallace_mac accumulator.
//   OP_W        operand width of the multiplier
//   PROD_W      product width (2 * OP_W)
//   mac_state_t frame FSM states of wallace_mac
package wallace_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned PROD_W = 8;

  typedef enum logic [1:0] {
    S_ACC,
    S_DRAIN,
    S_HOLD
  } mac_state_t;

endpackage

// File: rtl/wallace.sv
// Combinational 4x4 unsigned multiplier built as a Wallace-style carry-save tree.
//   a     in  OP_W    multiplicand
//   b     in  OP_W    multiplier
//   prod  out PROD_W  a * b
module wallace
  import wallace_pkg::*;
(
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [PROD_W-1:0] prod
);

  logic [PROD_W-1:0] pp [OP_W];
  logic [PROD_W-1:0] s1, c1, s2, c2;

  always_comb begin
    for (int i = 0; i < OP_W; i++) begin
      pp[i] = {{(PROD_W - OP_W){1'b0}}, a & {OP_W{b[i]}}} << i;
    end
    // Two 3:2 compressor levels reduce four partial products to sum + carry.
    // Bits carried past PROD_W are dropped: the true product always fits in PROD_W.
    s1   = pp[0] ^ pp[1] ^ pp[2];
    c1   = ((pp[0] & pp[1]) | (pp[0] & pp[2]) | (pp[1] & pp[2])) << 1;
    s2   = s1 ^ c1 ^ pp[3];
    c2   = ((s1 & c1) | (s1 & pp[3]) | (c1 & pp[3])) << 1;
    prod = s2 + c2;
  end

endmodule

// File: rtl/wallace_mac.sv
// Multiply-accumulate stage: multiplies a stream of operand pairs and sums the
// products over a frame terminated by in_last, then offers the frame result.
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    operand handshake; in_a, in_b, in_last carried with it
//   out_valid/out_ready  result handshake
//   out_sum              frame sum of products, modulo 2**ACC_W
//   out_count            number of terms in the frame, saturating at 2**CNT_W-1
//   out_ovf              accumulator carried out at least once during the frame
module wallace_mac
  import wallace_pkg::*;
#(
  parameter int unsigned ACC_W = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  mac_state_t        state_q, state_d;
  logic [OP_W-1:0]   p_a_q, p_a_d, p_b_q, p_b_d;
  logic              p_last_q, p_last_d, p_vld_q, p_vld_d;
  logic [ACC_W-1:0]  acc_q, acc_d, out_sum_q, out_sum_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, out_count_q, out_count_d;
  logic              ovf_q, ovf_d, out_ovf_q, out_ovf_d;
  logic              out_valid_q, out_valid_d;

  logic [PROD_W-1:0] prod;
  logic [ACC_W:0]    sum_ext;
  logic [CNT_W-1:0]  cnt_inc;
  logic              accept;

  wallace u_wallace (
    .a    (p_a_q),
    .b    (p_b_q),
    .prod (prod)
  );

  assign in_ready  = (state_q == S_ACC);
  assign accept    = in_valid && in_ready;
  // Extra top bit of sum_ext is the carry out of the accumulator.
  assign sum_ext   = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
  assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

  always_comb begin
    state_d     = state_q;
    p_a_d       = p_a_q;
    p_b_d       = p_b_q;
    p_last_d    = p_last_q;
    p_vld_d     = 1'b0;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;

    if (accept) begin
      p_a_d    = in_a;
      p_b_d    = in_b;
      p_last_d = in_last;
      p_vld_d  = 1'b1;
    end

    // Retire the registered pair; the last term publishes and restarts the frame.
    if (p_vld_q) begin
      if (p_last_q) begin
        out_sum_d   = sum_ext[ACC_W-1:0];
        out_count_d = cnt_inc;
        out_ovf_d   = ovf_q | sum_ext[ACC_W];
        out_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
        ovf_d       = 1'b0;
      end else begin
        acc_d = sum_ext[ACC_W-1:0];
        cnt_d = cnt_inc;
        ovf_d = ovf_q | sum_ext[ACC_W];
      end
    end

    unique case (state_q)
      S_ACC:   if (accept && in_last) state_d = S_DRAIN;
      S_DRAIN: state_d = S_HOLD;
      S_HOLD: begin
        if (out_ready) begin
          state_d     = S_ACC;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = S_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_ACC;
      p_a_q       <= '0;
      p_b_q       <= '0;
      p_last_q    <= 1'b0;
      p_vld_q     <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      p_a_q       <= p_a_d;
      p_b_q       <= p_b_d;
      p_last_q    <= p_last_d;
      p_vld_q     <= p_vld_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_wallace_mac.sv
// Bench for wallace_mac: a 16-bit and a 10-bit accumulator instance share one
// stimulus stream; each has its own expected-result queue and monitor.
module tb_wallace_mac;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_last, out_ready;
  logic [3:0] in_a, in_b;

  logic        rdy16, ov16, of16;
  logic [15:0] sum16;
  logic [7:0]  cnt16;
  logic        rdy10, ov10, of10;
  logic [9:0]  sum10;
  logic [7:0]  cnt10;

  typedef struct {
    int sum;
    int cnt;
    bit ovf;
  } exp_t;

  exp_t q16[$];
  exp_t q10[$];

  int vectors     = 0;
  int miscompares = 0;
  int or_mode     = 0;   // 0 random out_ready, 1 forced low, 2 forced high
  int frame_total = 0;
  int frame_n     = 0;

  wallace_mac #(.ACC_W(16), .CNT_W(8)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy16), .in_a(in_a), .in_b(in_b),
    .in_last(in_last), .out_valid(ov16), .out_ready(out_ready), .out_sum(sum16),
    .out_count(cnt16), .out_ovf(of16)
  );

  wallace_mac #(.ACC_W(10), .CNT_W(8)) dut10 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy10), .in_a(in_a), .in_b(in_b),
    .in_last(in_last), .out_valid(ov10), .out_ready(out_ready), .out_sum(sum10),
    .out_count(cnt10), .out_ovf(of10)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Frame result from plain arithmetic on the whole frame.
  function automatic exp_t model_result(input int total, input int n, input int w);
    exp_t e;
    e.sum = total % (1 << w);
    e.cnt = (n > 255) ? 255 : n;
    e.ovf = (total >= (1 << w));
    return e;
  endfunction

  task automatic model_accept(input int a, input int b, input bit last);
    frame_total += a * b;
    frame_n++;
    if (last) begin
      q16.push_back(model_result(frame_total, frame_n, 16));
      q10.push_back(model_result(frame_total, frame_n, 10));
      frame_total = 0;
      frame_n     = 0;
    end
  endtask

  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic last);
    int waitc = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    while (!rdy16) begin
      @(negedge clk);
      waitc++;
      if (waitc > 2000) begin
        $display("FAIL send timeout: in_ready got 0, required 1");
        $fatal(1);
      end
    end
    @(posedge clk);
    model_accept(a, b, last);
    #1 in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && (q16.size() != 0 || q10.size() != 0 || ov16); i++)
      @(negedge clk);
    check("drain queues", q16.size() + q10.size(), 0);
  endtask

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (or_mode)
        1:       out_ready = 1'b0;
        2:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst && ov16 && out_ready) begin
      if (q16.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL w16 result: got sum %0d, required no result", sum16);
      end else begin
        exp_t e;
        e = q16.pop_front();
        check("w16 sum", 32'(sum16), e.sum);
        check("w16 count", 32'(cnt16), e.cnt);
        check("w16 ovf", 32'(of16), 32'(e.ovf));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ov10 && out_ready) begin
      if (q10.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL w10 result: got sum %0d, required no result", sum10);
      end else begin
        exp_t e;
        e = q10.pop_front();
        check("w10 sum", 32'(sum10), e.sum);
        check("w10 count", 32'(cnt10), e.cnt);
        check("w10 ovf", 32'(of10), 32'(e.ovf));
      end
    end
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_last  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset in_ready", 32'(rdy16), 1);
    check("reset out_valid", 32'(ov16), 0);
    check("reset out_sum", 32'(sum16), 0);
    check("reset out_count", 32'(cnt16), 0);
    check("reset out_ovf", 32'(of16), 0);
    check("reset w10 out_valid", 32'(ov10), 0);

    // Two-term frame and output latency.
    send(4'd3, 4'd5, 1'b0);
    send(4'd7, 4'd9, 1'b1);
    @(negedge clk);
    check("t1 drain out_valid", 32'(ov16), 0);
    check("t1 drain in_ready", 32'(rdy16), 0);
    @(negedge clk);
    check("t1 latency out_valid", 32'(ov16), 1);
    check("t1 latency w10 out_valid", 32'(ov10), 1);
    drain();

    // Single pair held under backpressure while the next pair waits.
    or_mode = 1;
    idle(2);
    send(4'd15, 4'd15, 1'b1);
    fork
      send(4'd1, 4'd2, 1'b1);
      begin
        @(negedge clk);
        check("t2 drain in_ready", 32'(rdy16), 0);
        @(negedge clk);
        check("t2 out_valid", 32'(ov16), 1);
        repeat (5) begin
          @(negedge clk);
          check("t4 hold in_ready", 32'(rdy16), 0);
          check("t4 hold out_valid", 32'(ov16), 1);
          check("t4 hold out_sum", 32'(sum16), 225);
        end
        or_mode = 2;
        for (int i = 0; i < 10 && ov16; i++) @(negedge clk);
        check("t4 released out_valid", 32'(ov16), 0);
        check("t4 in_ready after handshake", 32'(rdy16), 1);
      end
    join
    drain();
    or_mode = 0;

    // Five 225 terms: wraps the 10-bit accumulator only.
    repeat (4) send(4'd15, 4'd15, 1'b0);
    send(4'd15, 4'd15, 1'b1);
    drain();

    // Reset mid-frame discards the partial frame.
    send(4'd4, 4'd4, 1'b0);
    send(4'd5, 4'd5, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    frame_total = 0;
    frame_n     = 0;
    check("t5 reset in_ready", 32'(rdy16), 1);
    check("t5 reset out_valid", 32'(ov16), 0);
    send(4'd2, 4'd3, 1'b1);
    drain();

    // Random frames with input bubbles and random out_ready.
    for (int f = 0; f < 40; f++) begin
      int len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        idle($urandom_range(0, 2));
        send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), i == len - 1);
      end
    end
    drain();

    // Count saturation without overflow, then saturation with 16-bit wrap.
    for (int i = 0; i < 300; i++) send(4'd1, 4'd1, i == 299);
    drain();
    for (int i = 0; i < 300; i++) send(4'd15, 4'd15, i == 299);
    drain();

    // Full operand sweep as single-pair frames with random gaps.
    for (int a = 1; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        send(4'(a), 4'(b), 1'b1);
      end
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
